// File: rtl/pc_unit.sv
// Program-counter unit at the head of fetch: stall hold, branch redirect, stalled-redirect latch, halt/resume.
// Optional debug trace ring of previous PC values enabled by defining PC_TRACE_EN.
module pc_unit #(
    parameter int                 WIDTH      = 16,
    parameter logic [WIDTH-1:0]   RESET_PC   = '0,
    parameter int                 INC        = 2,
    parameter int                 HIST_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          stall,
    input  logic                          redirect,
    input  logic [WIDTH-1:0]              redirect_pc,
    input  logic                          halt,
    input  logic                          resume,
    output logic [WIDTH-1:0]              pc,
    output logic [WIDTH-1:0]              pc_next_seq,
    output logic                          halted,
    output logic                          redirect_pending,
    input  logic [$clog2(HIST_DEPTH)-1:0] hist_idx,
    output logic [WIDTH-1:0]              hist_pc
);

    typedef enum logic [1:0] {
        S_RUN    = 2'd0,
        S_PEND   = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_target;
    logic [WIDTH-1:0] w_pc_next;
    logic [WIDTH-1:0] w_target_next;
    logic             w_update;
    logic [WIDTH-1:0] w_seq;

    assign w_seq            = r_pc + INC_W;
    assign pc               = r_pc;
    assign pc_next_seq      = w_seq;
    assign halted           = (r_state == S_HALTED);
    assign redirect_pending = (r_state == S_PEND);

    // w_update marks every pc write (equal-value writes included); holds never set it.
    always_comb begin
        w_state_next  = r_state;
        w_pc_next     = r_pc;
        w_target_next = r_target;
        w_update      = 1'b0;
        case (r_state)
            S_RUN: begin
                if (halt) begin
                    w_update     = 1'b1;
                    w_pc_next    = redirect ? redirect_pc : r_pc;
                    w_state_next = S_HALTED;
                end else if (redirect && !stall) begin
                    w_update  = 1'b1;
                    w_pc_next = redirect_pc;
                end else if (redirect) begin
                    w_target_next = redirect_pc;
                    w_state_next  = S_PEND;
                end else if (!stall) begin
                    w_update  = 1'b1;
                    w_pc_next = w_seq;
                end
            end
            S_PEND: begin
                if (halt) begin
                    w_update     = 1'b1;
                    w_pc_next    = redirect ? redirect_pc : r_target;
                    w_state_next = S_HALTED;
                end else if (stall) begin
                    if (redirect) begin
                        w_target_next = redirect_pc;
                    end
                end else begin
                    w_update     = 1'b1;
                    w_pc_next    = redirect ? redirect_pc : r_target;
                    w_state_next = S_RUN;
                end
            end
            S_HALTED: begin
                if (resume) begin
                    w_state_next = S_RUN;
                end
            end
            default: begin
                w_state_next = S_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_RUN;
            r_pc     <= RESET_PC;
            r_target <= RESET_PC;
        end else begin
            r_state  <= w_state_next;
            r_pc     <= w_pc_next;
            r_target <= w_target_next;
        end
    end

`ifdef PC_TRACE_EN
    // Shift ring: entry 0 always holds the most recently replaced pc.
    logic [WIDTH-1:0] r_hist [HIST_DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < HIST_DEPTH; i++) begin
                r_hist[i] <= RESET_PC;
            end
        end else if (w_update) begin
            r_hist[0] <= r_pc;
            for (int i = 1; i < HIST_DEPTH; i++) begin
                r_hist[i] <= r_hist[i-1];
            end
        end
    end

    assign hist_pc = r_hist[hist_idx];
`else
    logic w_unused_trace;

    assign w_unused_trace = ^{hist_idx, w_update};
    assign hist_pc        = '0;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit (default parameters) against a behavioural PC model.
// Trace-ring checks are active when PC_TRACE_EN is defined.
module tb_pc_unit;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        redirect;
    logic [15:0] redirectPc;
    logic        halt;
    logic        resume;
    logic [15:0] pc;
    logic [15:0] pcNextSeq;
    logic        halted;
    logic        redirectPending;
    logic [1:0]  histIdx;
    logic [15:0] histPc;

    int nChecks = 0;
    int nFails  = 0;

    // Reference model: current pc, mode flags, pending target and a history queue (front = newest).
    logic [15:0] mPc;
    logic        mHalted;
    logic        mPending;
    logic [15:0] mTarget;
    logic [15:0] mHist [$];

    pc_unit dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .stall            (stall),
        .redirect         (redirect),
        .redirect_pc      (redirectPc),
        .halt             (halt),
        .resume           (resume),
        .pc               (pc),
        .pc_next_seq      (pcNextSeq),
        .halted           (halted),
        .redirect_pending (redirectPending),
        .hist_idx         (histIdx),
        .hist_pc          (histPc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void modelReset();
        mPc      = 16'h0000;
        mHalted  = 1'b0;
        mPending = 1'b0;
        mTarget  = 16'h0000;
        mHist    = {16'h0000, 16'h0000, 16'h0000, 16'h0000};
    endfunction

    function automatic void modelWrite(input logic [15:0] v);
        mHist.push_front(mPc);
        void'(mHist.pop_back());
        mPc = v;
    endfunction

    function automatic void modelStep();
        if (mHalted) begin
            if (resume) mHalted = 1'b0;
        end else if (mPending) begin
            if (halt) begin
                modelWrite(redirect ? redirectPc : mTarget);
                mHalted  = 1'b1;
                mPending = 1'b0;
            end else if (stall) begin
                if (redirect) mTarget = redirectPc;
            end else begin
                modelWrite(redirect ? redirectPc : mTarget);
                mPending = 1'b0;
            end
        end else begin
            if (halt) begin
                modelWrite(redirect ? redirectPc : mPc);
                mHalted = 1'b1;
            end else if (redirect && !stall) begin
                modelWrite(redirectPc);
            end else if (redirect) begin
                mTarget  = redirectPc;
                mPending = 1'b1;
            end else if (!stall) begin
                modelWrite(16'((int'(mPc) + 2) % 65536));
            end
        end
    endfunction

    // Called at a negedge: drive inputs, advance the model across the next posedge, return at the next negedge.
    task automatic applyStimulus(input logic s, input logic r, input logic [15:0] rp,
                                 input logic h, input logic rs);
        stall      = s;
        redirect   = r;
        redirectPc = rp;
        halt       = h;
        resume     = rs;
        modelStep();
        @(negedge clk);
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n = 1'b0;
        applyStimulus(0, 0, 16'h0000, 0, 0);
        modelReset();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        stall = 0; redirect = 0; redirectPc = 0; halt = 0; resume = 0; histIdx = 0;
        #12;
        modelReset();
        nChecks++; if (pc !== 16'h0000) begin nFails++; $display("[TB] FAIL reset_pc got %h want 0000", pc); end
        nChecks++; if (pcNextSeq !== 16'h0002) begin nFails++; $display("[TB] FAIL reset_next_seq got %h want 0002", pcNextSeq); end
        nChecks++; if (halted !== 1'b0) begin nFails++; $display("[TB] FAIL reset_halted got %b want 0", halted); end
        nChecks++; if (redirectPending !== 1'b0) begin nFails++; $display("[TB] FAIL reset_pending got %b want 0", redirectPending); end
        nChecks++; if (histPc !== 16'h0000) begin nFails++; $display("[TB] FAIL reset_hist got %h want 0000", histPc); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_free_run();
        logic [15:0] expSeq [3];
        expSeq = '{16'h0002, 16'h0004, 16'h0006};
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 16'h0000, 0, 0);
            nChecks++; if (pc !== expSeq[i]) begin nFails++; $display("[TB] FAIL free_run_pc[%0d] got %h want %h", i, pc, expSeq[i]); end
            nChecks++; if (pcNextSeq !== 16'(expSeq[i] + 16'd2)) begin nFails++; $display("[TB] FAIL free_run_next_seq[%0d] got %h want %h", i, pcNextSeq, 16'(expSeq[i] + 16'd2)); end
        end
    endtask

    task automatic test_stall_redirect(input logic second, input logic [15:0] finalPc);
        doReset();
        applyStimulus(0, 0, 16'h0000, 0, 0);
        applyStimulus(0, 0, 16'h0000, 0, 0);
        applyStimulus(1, 1, 16'h0100, 0, 0);
        nChecks++; if (redirectPending !== 1'b1) begin nFails++; $display("[TB] FAIL stall_redir_pending got %b want 1", redirectPending); end
        nChecks++; if (pc !== 16'h0004) begin nFails++; $display("[TB] FAIL stall_redir_hold1 got %h want 0004", pc); end
        applyStimulus(1, second, 16'h0200, 0, 0);
        nChecks++; if (pc !== 16'h0004) begin nFails++; $display("[TB] FAIL stall_redir_hold2 got %h want 0004", pc); end
        applyStimulus(0, 0, 16'h0000, 0, 0);
        nChecks++; if (pc !== finalPc) begin nFails++; $display("[TB] FAIL stall_redir_release got %h want %h", pc, finalPc); end
        nChecks++; if (redirectPending !== 1'b0) begin nFails++; $display("[TB] FAIL stall_redir_cleared got %b want 0", redirectPending); end
        applyStimulus(0, 0, 16'h0000, 0, 0);
        nChecks++; if (pc !== 16'(finalPc + 16'd2)) begin nFails++; $display("[TB] FAIL stall_redir_after got %h want %h", pc, 16'(finalPc + 16'd2)); end
    endtask

    task automatic test_halt();
        doReset();
        applyStimulus(0, 1, 16'h0010, 0, 0);
        applyStimulus(0, 0, 16'h0000, 1, 0);
        nChecks++; if (halted !== 1'b1) begin nFails++; $display("[TB] FAIL halt_enter got %b want 1", halted); end
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'($urandom), 1'($urandom), 16'($urandom), 1'($urandom), 0);
            nChecks++; if (pc !== 16'h0010 || halted !== 1'b1) begin nFails++; $display("[TB] FAIL halt_hold[%0d] got pc=%h halted=%b want 0010/1", i, pc, halted); end
        end
        applyStimulus(0, 0, 16'h0000, 0, 1);
        nChecks++; if (halted !== 1'b0 || pc !== 16'h0010) begin nFails++; $display("[TB] FAIL halt_resume got pc=%h halted=%b want 0010/0", pc, halted); end
        applyStimulus(0, 0, 16'h0000, 0, 0);
        nChecks++; if (pc !== 16'h0012) begin nFails++; $display("[TB] FAIL halt_resume_inc got %h want 0012", pc); end
    endtask

    task automatic test_wrap();
        doReset();
        applyStimulus(0, 1, 16'hFFFE, 0, 0);
        nChecks++; if (pc !== 16'hFFFE || pcNextSeq !== 16'h0000) begin nFails++; $display("[TB] FAIL wrap_load got pc=%h seq=%h want fffe/0000", pc, pcNextSeq); end
        applyStimulus(0, 0, 16'h0000, 0, 0);
        nChecks++; if (pc !== 16'h0000) begin nFails++; $display("[TB] FAIL wrap_inc got %h want 0000", pc); end
    endtask

    task automatic test_async_reset_pend();
        doReset();
        applyStimulus(0, 0, 16'h0000, 0, 0);
        applyStimulus(1, 1, 16'h0080, 0, 0);
        nChecks++; if (redirectPending !== 1'b1) begin nFails++; $display("[TB] FAIL arst_enter_pend got %b want 1", redirectPending); end
        #2;
        rst_n = 1'b0;
        #1;
        nChecks++; if (pc !== 16'h0000 || redirectPending !== 1'b0) begin nFails++; $display("[TB] FAIL arst_immediate got pc=%h pend=%b want 0000/0", pc, redirectPending); end
        modelReset();
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(0, 0, 16'h0000, 0, 0);
        nChecks++; if (pc !== 16'h0002 || redirectPending !== 1'b0) begin nFails++; $display("[TB] FAIL arst_first_run got pc=%h pend=%b want 0002/0", pc, redirectPending); end
    endtask

`ifdef PC_TRACE_EN
    task automatic test_trace();
        logic [15:0] expHist [4];
        expHist = '{16'h0004, 16'h0002, 16'h0000, 16'h0000};
        doReset();
        applyStimulus(0, 0, 16'h0000, 0, 0);
        applyStimulus(0, 0, 16'h0000, 0, 0);
        applyStimulus(0, 1, 16'h0040, 0, 0);
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 4; i++) begin
                histIdx = 2'(i);
                #1;
                nChecks++; if (histPc !== expHist[i]) begin nFails++; $display("[TB] FAIL trace pass%0d idx%0d got %h want %h", pass, i, histPc, expHist[i]); end
            end
            applyStimulus(1, 0, 16'h0000, 0, 0);
            applyStimulus(1, 0, 16'h0000, 0, 0);
        end
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            histIdx = 2'($urandom);
            applyStimulus($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, 16'($urandom),
                          $urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0);
            nChecks++;
            if (pc !== mPc || pcNextSeq !== 16'(mPc + 16'd2) || halted !== mHalted || redirectPending !== mPending) begin
                nFails++;
                $display("[TB] FAIL random[%0d] got pc=%h seq=%h h=%b p=%b want pc=%h seq=%h h=%b p=%b",
                         i, pc, pcNextSeq, halted, redirectPending, mPc, 16'(mPc + 16'd2), mHalted, mPending);
            end
            nChecks++;
`ifdef PC_TRACE_EN
            if (histPc !== mHist[histIdx]) begin nFails++; $display("[TB] FAIL random_hist[%0d] idx%0d got %h want %h", i, histIdx, histPc, mHist[histIdx]); end
`else
            if (histPc !== 16'h0000) begin nFails++; $display("[TB] FAIL random_hist[%0d] got %h want 0000", i, histPc); end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_stall_redirect(1'b0, 16'h0100);
        test_stall_redirect(1'b1, 16'h0200);
        test_halt();
        test_wrap();
        test_async_reset_pend();
`ifdef PC_TRACE_EN
        test_trace();
`endif
        doReset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
# pc_unit

- Parametrised program-counter unit; next generation of the fixed 16-bit PC register.
- Adds configurable width, reset vector and increment, stall hold, branch/jump redirect, a redirect latched during stall, and a halt/resume state machine.
- Sits at the head of the fetch stage. It drives the instruction-memory address and the sequential PC+INC to decode.
- Optional trace ring of previous PC values for debug.

## Interface
- WIDTH, 16, PC width in bits
- RESET_PC, 0, PC value loaded on reset
- INC, 2, sequential increment (bytes per instruction)
- HIST_DEPTH, 4, trace ring entries (power of two, ≥2)

- clk  in  1  system clock, rising-edge
- rst_n  in  1  reset; asynchronous, active-low
- stall  in  1  hold PC this cycle
- redirect  in  1  load redirect_pc (branch/jump taken)
- redirect_pc  in  WIDTH  redirect target
- halt  in  1  enter HALTED
- resume  in  1  leave HALTED
- pc  out  WIDTH  current PC (registered)
- pc_next_seq  out  WIDTH  pc + INC, combinational
- halted  out  1  state == HALTED (registered)
- redirect_pending  out  1  state == PEND (registered)
- hist_idx  in  $clog2(HIST_DEPTH)  trace read index
- hist_pc  out  WIDTH  trace read data, combinational from ring

## Operation
- States: RUN, PEND, HALTED. Encoding is free; only the outputs are observable.
- RUN, evaluated in priority order:
  - halt: pc ← redirect ? redirect_pc : pc; go to HALTED.
  - redirect && !stall: pc ← redirect_pc.
  - redirect && stall: latch target ← redirect_pc; pc holds; go to PEND.
  - stall: pc holds.
  - Otherwise: pc ← pc + INC.
- PEND:
  - halt: pc ← redirect ? redirect_pc : target; go to HALTED.
  - stall: pc holds. A new redirect overwrites target; the newest target wins.
  - !stall: pc ← redirect ? redirect_pc : target; go to RUN.
- HALTED:
  - pc holds.
  - stall, redirect and halt are ignored.
  - resume: go to RUN. pc is unchanged that edge and increments from the next non-stalled RUN cycle.
- Arithmetic: pc + INC is modulo 2^WIDTH. 0xFFFE + 2 gives 0x0000 (WIDTH=16), with no flag.
- redirect_pc is loaded verbatim; no alignment is forced.
- A "pc update" is any edge where the pc value is written, including a write of an equal value. Holds are not updates.

## Timing
- pc, halted and redirect_pending change only on the rising clk edge, or asynchronously on rst_n low.
- Latency:
  - A redirect in RUN without stall is visible on pc one cycle later.
  - A pending redirect is visible one cycle after stall drops.
- halted asserts the cycle after halt is sampled. It deasserts the cycle after resume is sampled.
- Reset values:
  - pc = RESET_PC
  - pc_next_seq = RESET_PC + INC
  - halted = 0
  - redirect_pending = 0
  - state = RUN
  - pending target = RESET_PC
  - trace ring entries = RESET_PC
  - hist_pc = RESET_PC with PC_TRACE_EN, 0 without
- Reset mid-PEND or mid-HALTED discards the pending target and the halted state immediately. The first edge after rst_n rises behaves as RUN with pc = RESET_PC.

## Configuration
- PC_TRACE_EN defined:
  - On every pc update, the old pc value is pushed into a HIST_DEPTH-entry ring.
  - hist_pc = value pushed hist_idx updates ago; 0 = most recent.
  - The ring is not written on hold cycles or in HALTED.
- PC_TRACE_EN undefined:
  - No ring storage.
  - hist_idx is ignored; hist_pc is tied to 0.
  - All other behaviour is identical.

## Test plan
- Reset then 3 free-running cycles (defaults) → pc 0x0000, 0x0002, 0x0004, 0x0006; pc_next_seq always pc+2.
- stall for 2 cycles at pc=0x0004, with redirect=1 and redirect_pc=0x0100 on the first → redirect_pending=1, pc holds 0x0004. Stall drops → pc=0x0100, redirect_pending=0.
- Same case with a second redirect to 0x0200 during the stall → pc=0x0200 on release.
- halt at pc=0x0010 → halted=1, pc=0x0010 held for 5 cycles despite stall/redirect toggling. resume → halted=0, pc=0x0010, then 0x0012.
- redirect_pc=0xFFFE, then run → pc 0xFFFE, 0x0000 (wrap). Assert rst_n low mid-PEND → pc=0x0000 and redirect_pending=0 immediately, without waiting for a clock edge.
- PC_TRACE_EN: after pc sequence 0,2,4,0x40 (redirect) → hist_idx 0/1/2 read 0x0004/0x0002/0x0000; stall cycles leave the ring unchanged.
